// File: rtl/ysyx_mul_pkg.sv
// Shared types for the ysyx_mul iterative multiplier: FSM state encoding
// and the default operand width.
package ysyx_mul_pkg;

  localparam int MUL_DEFAULT_WIDTH = 64;

  typedef enum logic [1:0] {
    MUL_IDLE = 2'd0,
    MUL_BUSY = 2'd1,
    MUL_DONE = 2'd2
  } mul_state_e;

endpackage

// File: rtl/ysyx_mul.sv
// Radix-2 shift-add multiplier: one partial product per cycle over WIDTH
// iterations, returning the low WIDTH bits of A*B with a one-cycle done pulse.
module ysyx_mul
  import ysyx_mul_pkg::*;
#(
  parameter int WIDTH = MUL_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mul_valid,
  input  logic             flush,
  input  logic [WIDTH-1:0] multiplicand,
  input  logic [WIDTH-1:0] multiplier,
  output logic             mul_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output mul_state_e       dbg_state
);

  // Handshake: a request is taken on a rising edge where mul_valid and
  // mul_ready are both high and flush is low; operands are sampled only then.
  // out_valid is a single-cycle pulse with result stable from that cycle on.

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  mul_state_e       state_q;
  logic             mul_ready_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] result_q;
  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0] mplier_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] acc_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             last_iter;

  // Modular add: the carry out of the accumulator is the discarded high half.
  always_comb begin
    acc_d     = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    cnt_d     = cnt_q + 1'b1;
    last_iter = (cnt_q == CNT_LAST);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= MUL_IDLE;
      mul_ready_q <= 1'b1;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
    end else if (flush) begin
      // Abort wins over a new request and over the completing edge.
      state_q     <= MUL_IDLE;
      mul_ready_q <= 1'b1;
      out_valid_q <= 1'b0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
    end else begin
      case (state_q)
        MUL_IDLE: begin
          out_valid_q <= 1'b0;
          if (mul_valid) begin
            mcand_q     <= multiplicand;
            mplier_q    <= multiplier;
            acc_q       <= '0;
            cnt_q       <= '0;
            mul_ready_q <= 1'b0;
            state_q     <= MUL_BUSY;
          end
        end
        MUL_BUSY: begin
          acc_q    <= acc_d;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_d;
          if (last_iter) begin
            result_q    <= acc_d;
            out_valid_q <= 1'b1;
            state_q     <= MUL_DONE;
          end
        end
        MUL_DONE: begin
          out_valid_q <= 1'b0;
          mul_ready_q <= 1'b1;
          state_q     <= MUL_IDLE;
        end
        default: begin
          out_valid_q <= 1'b0;
          mul_ready_q <= 1'b1;
          state_q     <= MUL_IDLE;
        end
      endcase
    end
  end

  assign mul_ready = mul_ready_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_ysyx_mul.sv
// Self-checking bench for ysyx_mul: directed vectors plus a product sweep,
// flush and reset scenarios, checked through an expected-result queue.
module tb_ysyx_mul;
  import ysyx_mul_pkg::*;

  localparam int W = 64;
  localparam int N_SWEEP = 300;

  logic         clk;
  logic         rst;
  logic         mul_valid;
  logic         flush;
  logic [W-1:0] multiplicand;
  logic [W-1:0] multiplier;
  logic         mul_ready;
  logic         out_valid;
  logic [W-1:0] result;
  mul_state_e   dbg_state;

  logic [W-1:0] exp_q[$];
  int           acc_cyc_q[$];
  logic [W-1:0] last_res;
  int           cycle;
  int           n_vec;
  int           n_fail;

  ysyx_mul #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .mul_valid    (mul_valid),
    .flush        (flush),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .mul_ready    (mul_ready),
    .out_valid    (out_valid),
    .result       (result),
    .dbg_state    (dbg_state)
  );

  // clock / cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    n_vec++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cycle);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_fail++;
        $display("FAIL unexpected_out_valid: got out_valid=1 result=0x%0h, required no pulse (cycle %0d)",
                 result, cycle);
      end else begin
        logic [W-1:0] e;
        int a;
        e = exp_q.pop_front();
        a = acc_cyc_q.pop_front();
        check("result", result, e);
        check("latency", W'(cycle - a), W'(W));
      end
    end
  end

  // driver tasks
  task automatic wait_ready();
    int n;
    n = 0;
    while (mul_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (mul_ready !== 1'b1) check("ready_timeout", W'(mul_ready), W'(1));
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] exp, input bit hold);
    int n;
    wait_ready();
    mul_valid    = 1'b1;
    multiplicand = a;
    multiplier   = b;
    exp_q.push_back(exp);
    acc_cyc_q.push_back(cycle + 1);
    last_res = exp;
    @(negedge clk);
    if (!hold) mul_valid = 1'b0;
    n = 0;
    while (out_valid !== 1'b1 && n < W + 8) begin
      if (mul_ready !== 1'b0) check("ready_low_busy", W'(mul_ready), W'(0));
      if (hold) begin
        multiplicand = {$urandom(), $urandom()};
        multiplier   = {$urandom(), $urandom()};
      end
      @(negedge clk);
      n++;
    end
    if (out_valid !== 1'b1) check("done_timeout", W'(out_valid), W'(1));
    mul_valid = 1'b0;
  endtask

  // Accept an op, then hit it with flush or reset k edges after the accept edge.
  task automatic abort_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input int k, input bit use_rst);
    wait_ready();
    mul_valid    = 1'b1;
    multiplicand = a;
    multiplier   = b;
    @(negedge clk);
    mul_valid = 1'b0;
    repeat (k - 1) @(negedge clk);
    if (use_rst) rst = 1'b1;
    else flush = 1'b1;
    @(negedge clk);
    rst   = 1'b0;
    flush = 1'b0;
    if (use_rst) last_res = '0;
    check("abort_ready", W'(mul_ready), W'(1));
    check("abort_out_valid", W'(out_valid), W'(0));
    check("abort_result", result, last_res);
    check("abort_state", W'(dbg_state), W'(MUL_IDLE));
    repeat (W + 4) @(negedge clk);
  endtask

  initial begin
    logic [W-1:0] a;
    logic [W-1:0] b;
    n_vec = 0;
    n_fail = 0;
    last_res = '0;
    rst = 1'b1;
    mul_valid = 1'b0;
    flush = 1'b0;
    multiplicand = '0;
    multiplier = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_ready", W'(mul_ready), W'(1));
    check("reset_out_valid", W'(out_valid), W'(0));
    check("reset_result", result, '0);
    check("reset_state", W'(dbg_state), W'(MUL_IDLE));

    // directed vectors
    run_op(64'd3, 64'd5, 64'd15, 1'b0);
    run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0);
    run_op(64'h0000_0001_0000_0000, 64'h0000_0001_0000_0000, 64'd0, 1'b0);
    run_op(64'h0000_0001_0000_0001, 64'h0000_0001_0000_0001, 64'h0000_0002_0000_0001, 1'b0);
    run_op(64'h8000_0000_0000_0000, 64'd3, 64'h8000_0000_0000_0000, 1'b0);
    run_op(64'd0, 64'hDEAD_BEEF_CAFE_F00D, 64'd0, 1'b0);
    run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b1);
    run_op(64'd1000000, 64'd1000000, 64'd1000000000000, 1'b1);

    // product sweep with operands churning and mul_valid held while busy
    for (int i = 0; i < N_SWEEP; i++) begin
      a = {$urandom(), $urandom()};
      b = {$urandom(), $urandom()};
      if (i % 4 == 0) b = W'($urandom_range(0, 255));
      run_op(a, b, a * b, 1'b1);
    end

    // flush mid-operation and on the completing edge
    abort_op(64'd11, 64'd13, 30, 1'b0);
    abort_op(64'd17, 64'd19, W, 1'b0);

    // flush together with a request in idle: must not be taken
    wait_ready();
    mul_valid = 1'b1;
    flush = 1'b1;
    multiplicand = 64'd9;
    multiplier = 64'd9;
    @(negedge clk);
    mul_valid = 1'b0;
    flush = 1'b0;
    check("flush_req_ready", W'(mul_ready), W'(1));
    check("flush_req_state", W'(dbg_state), W'(MUL_IDLE));
    repeat (W + 4) @(negedge clk);

    // reset mid-operation, then a normal op
    abort_op(64'd123, 64'd456, 20, 1'b1);
    run_op(64'd7, 64'd6, 64'd42, 1'b0);

    repeat (4) @(negedge clk);
    if (exp_q.size() != 0) check("pending_results", W'(exp_q.size()), W'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
